sm_bus_matrix: RTL and testbench

SM_BUS_MATRIX -- requirements
Module: sm_bus_matrix

---
 rtl/sm_bus_matrix.sv | 119 +++++++++++
 tb/tb_sm_bus_matrix.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sm_bus_matrix.sv
// sm_bus_matrix: single-outstanding host-to-N-device bus matrix with priority address decode,
// registered device request/response and an optional device wait timeout.
module sm_bus_matrix #(
  parameter int                   N_DEV       = 4,
  parameter logic [32*N_DEV-1:0]  REGION_BASE = {N_DEV{32'h0}},
  parameter logic [32*N_DEV-1:0]  REGION_MASK = {N_DEV{32'h0}},
  parameter int                   TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          a,
  input  logic                 we,
  input  logic [31:0]          wd,
  input  logic                 valid,
  output logic                 ready,
  output logic [31:0]          rd,
  output logic                 err,
  output logic [N_DEV-1:0]     dev_valid,
  output logic [31:0]          dev_a,
  output logic                 dev_we,
  output logic [31:0]          dev_wd,
  input  logic [N_DEV-1:0]     dev_ready,
  input  logic [32*N_DEV-1:0]  dev_rd,
  input  logic [N_DEV-1:0]     dev_err
);
  localparam int SW = N_DEV > 1 ? $clog2(N_DEV) : 1;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t           state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d, hit_idx;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      dev_a_q, dev_a_d, dev_wd_q, dev_wd_d, rd_q, rd_d;
  logic             dev_we_q, dev_we_d, err_q, err_d, ready_q, ready_d, hit;
  logic [N_DEV-1:0] dev_valid_q, dev_valid_d;
  logic             sel_ready, sel_err;
  logic [31:0]      sel_rd;
  // Scan high to low so the lowest matching channel is the last one written.
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = N_DEV - 1; i >= 0; i--)
      if ((a & REGION_MASK[32*i +: 32]) == REGION_BASE[32*i +: 32]) begin
        hit = 1'b1;
        hit_idx = SW'(i);
      end
  end
  assign sel_ready = dev_ready[sel_q];
  assign sel_err   = dev_err[sel_q];
  assign sel_rd    = dev_rd[32*sel_q +: 32];
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    dev_a_d  = dev_a_q;
    dev_we_d = dev_we_q;
    dev_wd_d = dev_wd_q;
    rd_d     = rd_q;
    err_d    = err_q;
    if (state_q == S_IDLE && valid && hit) begin
      state_d  = S_WAIT;
      sel_d    = hit_idx;
      cnt_d    = '0;
      dev_a_d  = a;
      dev_we_d = we;
      dev_wd_d = wd;
    end else if (state_q == S_IDLE && valid) begin
      state_d = S_RESP;
      rd_d    = '0;
      err_d   = 1'b1;
    end else if (state_q == S_WAIT && sel_ready) begin
      state_d = S_RESP;
      rd_d    = dev_we_q ? 32'h0 : sel_rd;
      err_d   = sel_err;
    end else if (state_q == S_WAIT && TIMEOUT != 0 && cnt_q == CNT_LAST) begin
      state_d = S_RESP;
      rd_d    = '0;
      err_d   = 1'b1;
    end else if (state_q == S_WAIT) begin
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    end else if (state_q == S_RESP) begin
      state_d = S_IDLE;
    end
    ready_d     = state_d == S_RESP;
    dev_valid_d = state_d == S_WAIT ? N_DEV'(1) << sel_d : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      dev_a_q     <= '0;
      dev_we_q    <= 1'b0;
      dev_wd_q    <= '0;
      rd_q        <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
      dev_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      dev_a_q     <= dev_a_d;
      dev_we_q    <= dev_we_d;
      dev_wd_q    <= dev_wd_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      dev_valid_q <= dev_valid_d;
    end
  end
  assign ready     = ready_q;
  assign rd        = rd_q;
  assign err       = err_q;
  assign dev_valid = dev_valid_q;
  assign dev_a     = dev_a_q;
  assign dev_we    = dev_we_q;
  assign dev_wd    = dev_wd_q;
endmodule

// File: tb/tb_sm_bus_matrix.sv
// tb_sm_bus_matrix: directed table-driven bench for sm_bus_matrix with a simple
// programmable-delay device model and hand-written back-to-back and reset sequences.
module tb_sm_bus_matrix;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] a = '0, wd = '0;
  logic        we = 1'b0, valid = 1'b0;
  logic        ready, err;
  logic [31:0] rd, dev_a, dev_wd;
  logic        dev_we;
  logic [2:0]  dev_valid, dev_ready, dev_err, junk = '0;
  logic [95:0] dev_rd;
  logic [31:0] rdv = '0;
  logic        de = 1'b0;
  int          dly = 0;
  int          wcnt [3];
  int          total = 0, bad = 0;

  sm_bus_matrix #(
    .N_DEV(3),
    .REGION_BASE({32'h00000000, 32'h20000000, 32'h00000000}),
    .REGION_MASK({32'hF0000000, 32'hE0000000, 32'hE0000000}),
    .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .we(we), .wd(wd), .valid(valid),
    .ready(ready), .rd(rd), .err(err), .dev_valid(dev_valid), .dev_a(dev_a),
    .dev_we(dev_we), .dev_wd(dev_wd), .dev_ready(dev_ready), .dev_rd(dev_rd),
    .dev_err(dev_err)
  );

  always #5 clk = ~clk;

  // Device model: channel i answers after dly wait cycles (dly<0 never); junk adds stray ready bits.
  always @(posedge clk or negedge rst_n)
    for (int i = 0; i < 3; i++) wcnt[i] <= (rst_n && dev_valid[i]) ? wcnt[i] + 1 : 0;
  always_comb begin
    dev_ready = junk;
    for (int i = 0; i < 3; i++)
      if (dev_valid[i] && dly >= 0 && wcnt[i] == dly) dev_ready[i] = 1'b1;
  end
  assign dev_rd  = {rdv + 32'd2, rdv + 32'd1, rdv};
  assign dev_err = {3{de}};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic run(input logic [31:0] aa, input logic w, input logic [31:0] d,
                     output int lat, output int dvc, output logic [2:0] dvs,
                     output logic [31:0] r, output logic e,
                     output logic [31:0] da, output logic [31:0] dd, output logic dw);
    @(negedge clk);
    a = aa; we = w; wd = d; valid = 1'b1;
    lat = 0; dvc = 0; dvs = '0; da = '0; dd = '0; dw = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (dev_valid != 0) begin
        if (dvc == 0) begin da = dev_a; dd = dev_wd; dw = dev_we; end
        dvc++;
        dvs |= dev_valid;
      end
    end while (!ready && lat < 50);
    r = rd; e = err;
    @(negedge clk);
    valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a; logic we; logic [31:0] wd;
    int dly; logic [31:0] rdv; logic de; logic [2:0] junk;
    int lat; int dvc; logic [2:0] dv; logic [31:0] rd; logic err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int lat, dvc, n;
    logic [2:0] dvs;
    logic [31:0] r, da, dd;
    logic e, dw;
    tbl[0] = '{32'h00000010, 1'b0, 32'h0,        0, 32'h12345678, 1'b0, 3'b000, 2, 1, 3'b001, 32'h12345678, 1'b0};
    tbl[1] = '{32'h20000004, 1'b1, 32'hA5A5A5A5, 3, 32'hDEADBEEF, 1'b0, 3'b101, 5, 4, 3'b010, 32'h0,        1'b0};
    tbl[2] = '{32'h40000000, 1'b0, 32'h0,        0, 32'h11111111, 1'b0, 3'b000, 1, 0, 3'b000, 32'h0,        1'b1};
    tbl[3] = '{32'h20000000, 1'b0, 32'h0,       -1, 32'h22222222, 1'b0, 3'b101, 5, 4, 3'b010, 32'h0,        1'b1};
    tbl[4] = '{32'h00000024, 1'b0, 32'h0,        1, 32'h00001000, 1'b1, 3'b000, 3, 2, 3'b001, 32'h00001000, 1'b1};
    tbl[5] = '{32'h00000000, 1'b0, 32'h0,        0, 32'hCAFE0000, 1'b0, 3'b000, 2, 1, 3'b001, 32'hCAFE0000, 1'b0};
    tbl[6] = '{32'h3FFFFFFC, 1'b0, 32'h0,        2, 32'h00000055, 1'b0, 3'b000, 4, 3, 3'b010, 32'h00000056, 1'b0};
    tbl[7] = '{32'h0000001C, 1'b1, 32'h5A5A0000, 0, 32'h33333333, 1'b1, 3'b110, 2, 1, 3'b001, 32'h0,        1'b1};
    tbl[8] = '{32'hE0000000, 1'b1, 32'h0,        0, 32'h44444444, 1'b0, 3'b000, 1, 0, 3'b000, 32'h0,        1'b1};
    tbl[9] = '{32'h00000000, 1'b0, 32'h0,        3, 32'h0BADF00D, 1'b0, 3'b000, 5, 4, 3'b001, 32'h0BADF00D, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 32'(ready), 32'h0);
    chk("reset rd", rd, 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset dev_valid", 32'(dev_valid), 32'h0);
    chk("reset dev_a", dev_a, 32'h0);
    chk("reset dev_we", 32'(dev_we), 32'h0);
    chk("reset dev_wd", dev_wd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      dly = tbl[i].dly; rdv = tbl[i].rdv; de = tbl[i].de; junk = tbl[i].junk;
      run(tbl[i].a, tbl[i].we, tbl[i].wd, lat, dvc, dvs, r, e, da, dd, dw);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("v%0d dev_valid cycles", i), 32'(dvc), 32'(tbl[i].dvc));
      chk($sformatf("v%0d dev_valid bits", i), 32'(dvs), 32'(tbl[i].dv));
      chk($sformatf("v%0d rd", i), r, tbl[i].rd);
      chk($sformatf("v%0d err", i), 32'(e), 32'(tbl[i].err));
      if (tbl[i].dv != 0) begin
        chk($sformatf("v%0d dev_a", i), da, tbl[i].a);
        chk($sformatf("v%0d dev_wd", i), dd, tbl[i].wd);
        chk($sformatf("v%0d dev_we", i), 32'(dw), 32'(tbl[i].we));
      end
      junk = '0;
    end

    // Back-to-back: valid held through ready starts the next request after one idle cycle.
    dly = 1; rdv = 32'h77; de = 1'b0;
    @(negedge clk);
    a = 32'h10; we = 1'b0; valid = 1'b1; n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready && n < 20);
    chk("b2b first latency", 32'(n), 32'd3);
    chk("b2b first rd", rd, 32'h77);
    @(posedge clk); #1;
    chk("b2b idle dev_valid", 32'(dev_valid), 32'h0);
    chk("b2b idle ready", 32'(ready), 32'h0);
    @(posedge clk); #1;
    chk("b2b second dev_valid", 32'(dev_valid), 32'h1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ready && n < 20);
    chk("b2b second wait", 32'(n), 32'd2);
    chk("b2b second rd", rd, 32'h77);
    @(negedge clk);
    valid = 1'b0;

    // Reset pulsed while waiting on a device that never answers.
    dly = -1;
    @(negedge clk);
    a = 32'h20000000; we = 1'b0; valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre-reset dev_valid", 32'(dev_valid), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset dev_valid", 32'(dev_valid), 32'h0);
    chk("async reset dev_a", dev_a, 32'h0);
    chk("async reset rd", rd, 32'h0);
    chk("async reset err", 32'(err), 32'h0);
    chk("async reset ready", 32'(ready), 32'h0);
    valid = 1'b0;
    n = 0;
    repeat (3) begin @(posedge clk); #1; if (ready) n++; end
    chk("no ready in reset", 32'(n), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dly = 0; rdv = 32'h3C;
    run(32'h00000004, 1'b0, 32'h0, lat, dvc, dvs, r, e, da, dd, dw);
    chk("post-reset latency", 32'(lat), 32'd2);
    chk("post-reset rd", r, 32'h3C);
    chk("post-reset err", 32'(e), 32'h0);
    chk("post-reset dev_valid bits", 32'(dvs), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
